addsub_lane_pipe: RTL
=====================

// Module: addsub_lane_pipe
// PURPOSE
//  Multi-lane signed add/subtract pipeline with depth-parametrised registers and full
//  valid/ready backpressure (stall, no drop). Optional per-lane saturation and an
//  overflow-event counter. Drop-in arithmetic stage for the demod datapath between
//  the mixer/filter blocks and downstream accumulators.
// PARAMETERS
//  DATA_W      24  signed input width per lane
//  N_LANES     2   independent lanes sharing one handshake (e.g. I/Q)
//  PIPE_STAGES 2   register stages, >=1; latency in cycles with no stall
//  SAT         1   1: saturate to DATA_W bits; 0: exact DATA_W+1-bit result
//  CNT_W       16  overflow-event counter width
//  OUT_W = SAT ? DATA_W : DATA_W+1  (localparam, derived)
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               async active-high reset
//  i_valid    in   1               upstream data valid
//  o_ready    out  1               block can accept input this cycle
//  i_mode     in   1               0: a+b, 1: a-b (applies to all lanes, sampled with data)
//  i_a        in   N_LANES*DATA_W  lane k at [k*DATA_W +: DATA_W], signed
//  i_b        in   N_LANES*DATA_W  as i_a
//  o_valid    out  1               output data valid
//  i_ready    in   1               downstream accepts output
//  o_c        out  N_LANES*OUT_W   lane k at [k*OUT_W +: OUT_W], signed
//  o_ovf      out  N_LANES         lane k result clipped (always 0 when SAT=0)
//  i_clr_cnt  in   1               sync clear of o_ovf_cnt
//  o_ovf_cnt  out  CNT_W           count of output transfers with any o_ovf bit set
// BEHAVIOUR
//  - reset asserted (any time, async): all stage valids, o_valid, o_c, o_ovf, o_ovf_cnt -> 0;
//    in-flight data discarded. o_ready follows from cleared valids (=1 once reset released).
//  - Input transfer: i_valid && o_ready at posedge. Output transfer: o_valid && i_ready.
//  - Stage s holds valid bit v[s] + data. Stage s loads when !v[s] || stage s advances;
//    last stage advances on output transfer. o_ready = !v[0] || adv[0] (combinational
//    ready chain through stages; no skid buffer, no bubbles required when flowing).
//  - Throughput 1 transfer/cycle when i_ready held 1; latency PIPE_STAGES cycles.
//  - Stall: while o_valid && !i_ready, o_c/o_ovf/o_valid hold stable; earlier empty
//    stages still fill; once all stages full o_ready=0. No data lost or duplicated.
//  - Empty stage after a transfer with no new input: v clears, data regs may hold stale.
//  - Arithmetic in stage 0: r = sext(a) +/- sext(b) in DATA_W+1 bits, exact.
//    SAT=1: r > 2^(DATA_W-1)-1 -> max, o_ovf=1; r < -2^(DATA_W-1) -> min, o_ovf=1;
//    else r[DATA_W-1:0], o_ovf=0. Saturation done in stage 0, later stages are delay.
//    SAT=0: o_c = r, o_ovf = 0.
//  - Lanes independent; mode shared, carried through pipeline with its data.
//  - o_ovf_cnt: +1 on output transfer with |o_ovf; saturates at 2^CNT_W-1 (no wrap).
//    i_clr_cnt wins over simultaneous increment (result 0).
//  - i_valid deasserted without transfer is legal; inputs ignored when i_valid=0.
// TESTING  (DATA_W=8, N_LANES=2, PIPE_STAGES=2, SAT=1, CNT_W=4 unless noted)
//  1. a={10,-3}, b={5,4}, mode=0, i_ready=1 -> 2 cycles later o_valid=1, o_c={15,1}, o_ovf=00.
//  2. a={100,-100}, b={50,50}, mode=0 then mode=1 -> {127,-50} ovf=01; then {50,-128} ovf=10;
//     o_ovf_cnt=2.
//  3. Stream 6 beats, i_ready=0 from cycle 3 for 4 cycles -> o_ready drops after 2 stages fill,
//     o_c held stable, all 6 results delivered in order, none dropped/duplicated.
//  4. SAT=0 build: a=127, b=127 add -> o_c=254 (9-bit), o_ovf=0; a=-128, b=127 sub -> -255.
//  5. Force 20 overflowing transfers -> o_ovf_cnt sticks at 15; i_clr_cnt with overflow beat
//     same cycle -> 0.
//  6. Assert reset mid-stream with 2 beats in flight -> o_valid/o_c/o_ovf_cnt 0 immediately
//     (async); after release, o_ready=1 and next beat emerges after 2 cycles.

Source files
------------

// File: rtl/addsub_lane_pipe_if.sv
// Handshake and data bundle for addsub_lane_pipe: upstream valid/ready with operands,
// downstream valid/ready with results, plus the overflow counter and its clear.
interface addsub_lane_pipe_if #(
    parameter int DATA_W  = 24,
    parameter int N_LANES = 2,
    parameter int SAT     = 1,
    parameter int CNT_W   = 16
);
    localparam int OUT_W = (SAT != 0) ? DATA_W : DATA_W + 1;

    logic                       i_valid;
    logic                       o_ready;
    logic                       i_mode;
    logic [N_LANES*DATA_W-1:0]  i_a;
    logic [N_LANES*DATA_W-1:0]  i_b;
    logic                       o_valid;
    logic                       i_ready;
    logic [N_LANES*OUT_W-1:0]   o_c;
    logic [N_LANES-1:0]         o_ovf;
    logic                       i_clr_cnt;
    logic [CNT_W-1:0]           o_ovf_cnt;

    modport slave (
        input  i_valid, i_mode, i_a, i_b, i_ready, i_clr_cnt,
        output o_ready, o_valid, o_c, o_ovf, o_ovf_cnt
    );

    modport master (
        output i_valid, i_mode, i_a, i_b, i_ready, i_clr_cnt,
        input  o_ready, o_valid, o_c, o_ovf, o_ovf_cnt
    );
endinterface

// File: rtl/addsub_lane_pipe.sv
// Per-lane signed a+b / a-b with optional saturation, delayed through PIPE_STAGES registers.
// Latency PIPE_STAGES cycles; ready ripples combinationally back through the stages, so a stall fills bubbles then holds.
module addsub_lane_pipe #(
    parameter int DATA_W      = 24,
    parameter int N_LANES     = 2,
    parameter int PIPE_STAGES = 2,
    parameter int SAT         = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    addsub_lane_pipe_if.slave bus
);
    localparam int OUT_W = (SAT != 0) ? DATA_W : DATA_W + 1;
    localparam int LAST  = PIPE_STAGES - 1;
    localparam int C_W   = N_LANES * OUT_W;
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] ld;
    logic [C_W-1:0]         c_q   [PIPE_STAGES];
    logic [N_LANES-1:0]     ovf_q [PIPE_STAGES];
    logic [C_W-1:0]         c_d;
    logic [N_LANES-1:0]     ovf_d;
    logic [CNT_W-1:0]       cnt;
    logic                   out_xfer;

    // A stage may load when it is empty or when everything downstream of it moves.
    always_comb begin
        logic rdy;
        rdy = bus.i_ready;
        ld  = '0;
        for (int s = LAST; s >= 0; s--) begin
            rdy   = !vld[s] || rdy;
            ld[s] = rdy;
        end
    end

    always_comb begin
        logic signed [DATA_W:0] ax;
        logic signed [DATA_W:0] bx;
        logic signed [DATA_W:0] r;
        c_d   = '0;
        ovf_d = '0;
        ax    = '0;
        bx    = '0;
        r     = '0;
        for (int k = 0; k < N_LANES; k++) begin
            ax = {bus.i_a[k*DATA_W + DATA_W - 1], bus.i_a[k*DATA_W +: DATA_W]};
            bx = {bus.i_b[k*DATA_W + DATA_W - 1], bus.i_b[k*DATA_W +: DATA_W]};
            r  = bus.i_mode ? (ax - bx) : (ax + bx);
            // The two top bits of the exact sum disagree only when it leaves DATA_W range.
            if ((SAT != 0) && (r[DATA_W] != r[DATA_W-1])) begin
                ovf_d[k]              = 1'b1;
                c_d[k*OUT_W +: OUT_W] = r[DATA_W] ? OUT_W'(SAT_MIN) : OUT_W'(SAT_MAX);
            end else begin
                c_d[k*OUT_W +: OUT_W] = OUT_W'(r);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                c_q[s]   <= '0;
                ovf_q[s] <= '0;
            end
        end else begin
            if (ld[0]) begin
                vld[0] <= bus.i_valid;
                if (bus.i_valid) begin
                    c_q[0]   <= c_d;
                    ovf_q[0] <= ovf_d;
                end
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                if (ld[s]) begin
                    vld[s] <= vld[s-1];
                    if (vld[s-1]) begin
                        c_q[s]   <= c_q[s-1];
                        ovf_q[s] <= ovf_q[s-1];
                    end
                end
            end
        end
    end

    assign out_xfer = vld[LAST] && bus.i_ready;

    // Counts clipped output beats; clear beats a same-cycle increment and the count never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.i_clr_cnt) begin
            cnt <= '0;
        end else if (out_xfer && (|ovf_q[LAST]) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.o_ready   = ld[0];
    assign bus.o_valid   = vld[LAST];
    assign bus.o_c       = c_q[LAST];
    assign bus.o_ovf     = ovf_q[LAST];
    assign bus.o_ovf_cnt = cnt;
endmodule
